// File: rtl/ext_mem_loader_if.sv
// Host/loader signal bundle: command inputs, input/output word streams,
// both CPU ext memory ports and CPU control. Every handshake is valid/ready:
// a word moves on a rising edge where valid and ready are both high; the
// sender holds valid and data stable until then, and ready may be high
// before, or in the same cycle as, valid.
interface ext_mem_loader_if #(
  parameter int CNT_W = 16,
  parameter int RUN_W = 32
);
  logic             start;
  logic [CNT_W-1:0] imem_words;
  logic [CNT_W-1:0] dmem_words;
  logic [RUN_W-1:0] run_cycles;
  logic [CNT_W-1:0] dump_words;
  logic             in_valid;
  logic             in_ready;
  logic [63:0]      in_data;
  logic             out_valid;
  logic             out_ready;
  logic [63:0]      out_data;
  logic [63:0]      addr_ext;
  logic             wen_ext;
  logic             ren_ext;
  logic [31:0]      wdata_ext;
  logic [63:0]      addr_ext_2;
  logic             wen_ext_2;
  logic             ren_ext_2;
  logic [63:0]      wdata_ext_2;
  logic [63:0]      rdata_ext_2;
  logic             cpu_arst_n;
  logic             cpu_enable;
  logic             busy;
  logic             done;

  modport master (
    input  start, imem_words, dmem_words, run_cycles, dump_words,
    input  in_valid, in_data, out_ready, rdata_ext_2,
    output in_ready, out_valid, out_data,
    output addr_ext, wen_ext, ren_ext, wdata_ext,
    output addr_ext_2, wen_ext_2, ren_ext_2, wdata_ext_2,
    output cpu_arst_n, cpu_enable, busy, done
  );

  modport slave (
    output start, imem_words, dmem_words, run_cycles, dump_words,
    output in_valid, in_data, out_ready, rdata_ext_2,
    input  in_ready, out_valid, out_data,
    input  addr_ext, wen_ext, ren_ext, wdata_ext,
    input  addr_ext_2, wen_ext_2, ren_ext_2, wdata_ext_2,
    input  cpu_arst_n, cpu_enable, busy, done
  );
endinterface

// File: rtl/ext_mem_loader.sv
// Loads instruction and data memory through the CPU ext ports, runs the CPU
// for a programmed number of cycles, then streams a data-memory window out.
module ext_mem_loader #(
  parameter int CNT_W       = 16,
  parameter int RUN_W       = 32,
  parameter int IMEM_STRIDE = 4,
  parameter int DMEM_STRIDE = 8
) (
  input  logic               clk,
  input  logic               rst,
  ext_mem_loader_if.master   bus,
  output logic [2:0]         dbg_state_o
);

  typedef enum logic [2:0] {
    IDLE, LOAD_I, LOAD_D, RUN, DUMP_RD, DUMP_CAP, DUMP_OUT, DONE
  } state_t;

  state_t           state_q;
  logic [CNT_W-1:0] i_left_q, d_left_q, dump_left_q;
  logic [RUN_W-1:0] run_left_q;
  logic [63:0]      i_addr_q, d_addr_q;
  logic             in_ready_q, out_valid_q;
  logic [63:0]      out_data_q;
  logic [63:0]      addr_ext_q, addr_ext_2_q;
  logic             wen_ext_q, wen_ext_2_q, ren_ext_2_q;
  logic [31:0]      wdata_ext_q;
  logic [63:0]      wdata_ext_2_q;
  logic             cpu_arst_n_q, cpu_enable_q, busy_q, done_q;

  logic in_hs, out_hs;
  assign in_hs  = bus.in_valid & in_ready_q;
  assign out_hs = out_valid_q & bus.out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      i_left_q      <= '0;
      d_left_q      <= '0;
      dump_left_q   <= '0;
      run_left_q    <= '0;
      i_addr_q      <= '0;
      d_addr_q      <= '0;
      in_ready_q    <= 1'b0;
      out_valid_q   <= 1'b0;
      out_data_q    <= '0;
      addr_ext_q    <= '0;
      addr_ext_2_q  <= '0;
      wen_ext_q     <= 1'b0;
      wen_ext_2_q   <= 1'b0;
      ren_ext_2_q   <= 1'b0;
      wdata_ext_q   <= '0;
      wdata_ext_2_q <= '0;
      cpu_arst_n_q  <= 1'b0;
      cpu_enable_q  <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      // Memory strobes and done are single-cycle pulses unless re-armed below.
      wen_ext_q   <= 1'b0;
      wen_ext_2_q <= 1'b0;
      ren_ext_2_q <= 1'b0;
      done_q      <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.start) begin
            busy_q      <= 1'b1;
            i_left_q    <= bus.imem_words;
            d_left_q    <= bus.dmem_words;
            run_left_q  <= bus.run_cycles;
            dump_left_q <= bus.dump_words;
            i_addr_q    <= '0;
            d_addr_q    <= '0;
            if (bus.imem_words != '0) begin
              state_q      <= LOAD_I;
              in_ready_q   <= 1'b1;
              cpu_arst_n_q <= 1'b0;
            end else if (bus.dmem_words != '0) begin
              state_q      <= LOAD_D;
              in_ready_q   <= 1'b1;
              cpu_arst_n_q <= 1'b0;
            end else begin
              state_q      <= RUN;
              cpu_arst_n_q <= 1'b1;
            end
          end
        end
        LOAD_I: begin
          if (in_hs) begin
            wen_ext_q   <= 1'b1;
            addr_ext_q  <= i_addr_q;
            wdata_ext_q <= bus.in_data[31:0];
            i_addr_q    <= i_addr_q + 64'(IMEM_STRIDE);
            i_left_q    <= i_left_q - 1'b1;
            if (i_left_q == CNT_W'(1)) begin
              if (d_left_q != '0) begin
                state_q <= LOAD_D;
              end else begin
                state_q      <= RUN;
                in_ready_q   <= 1'b0;
                cpu_arst_n_q <= 1'b1;
              end
            end
          end
        end
        LOAD_D: begin
          if (in_hs) begin
            wen_ext_2_q   <= 1'b1;
            addr_ext_2_q  <= d_addr_q;
            wdata_ext_2_q <= bus.in_data;
            d_addr_q      <= d_addr_q + 64'(DMEM_STRIDE);
            d_left_q      <= d_left_q - 1'b1;
            if (d_left_q == CNT_W'(1)) begin
              state_q      <= RUN;
              in_ready_q   <= 1'b0;
              cpu_arst_n_q <= 1'b1;
            end
          end
        end
        RUN: begin
          // The entry cycle carries the last load write, so enable starts one cycle later.
          if (run_left_q == '0) begin
            cpu_enable_q <= 1'b0;
            if (dump_left_q != '0) begin
              state_q      <= DUMP_RD;
              ren_ext_2_q  <= 1'b1;
              addr_ext_2_q <= '0;
              d_addr_q     <= 64'(DMEM_STRIDE);
            end else begin
              state_q <= DONE;
              done_q  <= 1'b1;
            end
          end else begin
            cpu_enable_q <= 1'b1;
            run_left_q   <= run_left_q - 1'b1;
          end
        end
        DUMP_RD: begin
          state_q <= DUMP_CAP;
        end
        DUMP_CAP: begin
          out_data_q  <= bus.rdata_ext_2;
          out_valid_q <= 1'b1;
          state_q     <= DUMP_OUT;
        end
        DUMP_OUT: begin
          if (out_hs) begin
            out_valid_q <= 1'b0;
            dump_left_q <= dump_left_q - 1'b1;
            if (dump_left_q == CNT_W'(1)) begin
              state_q <= DONE;
              done_q  <= 1'b1;
            end else begin
              state_q      <= DUMP_RD;
              ren_ext_2_q  <= 1'b1;
              addr_ext_2_q <= d_addr_q;
              d_addr_q     <= d_addr_q + 64'(DMEM_STRIDE);
            end
          end
        end
        DONE: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.in_ready    = in_ready_q;
  assign bus.out_valid   = out_valid_q;
  assign bus.out_data    = out_data_q;
  assign bus.addr_ext    = addr_ext_q;
  assign bus.wen_ext     = wen_ext_q;
  assign bus.ren_ext     = 1'b0;
  assign bus.wdata_ext   = wdata_ext_q;
  assign bus.addr_ext_2  = addr_ext_2_q;
  assign bus.wen_ext_2   = wen_ext_2_q;
  assign bus.ren_ext_2   = ren_ext_2_q;
  assign bus.wdata_ext_2 = wdata_ext_2_q;
  assign bus.cpu_arst_n  = cpu_arst_n_q;
  assign bus.cpu_enable  = cpu_enable_q;
  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign dbg_state_o     = state_q;

endmodule

// File: tb/tb_ext_mem_loader.sv
// Self-checking bench for ext_mem_loader: scoreboard queues for imem writes,
// dmem writes and dump words, plus per-command timing checks.
module tb_ext_mem_loader;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_LOAD_D = 3'd2;
  localparam logic [2:0] ST_RUN    = 3'd3;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [2:0] dbg_state;

  always #5 clk = ~clk;

  ext_mem_loader_if #(.CNT_W(16), .RUN_W(32)) bus ();

  ext_mem_loader #(.CNT_W(16), .RUN_W(32), .IMEM_STRIDE(4), .DMEM_STRIDE(8)) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .dbg_state_o (dbg_state)
  );

  int chk_cnt = 0;
  int pass_cnt = 0;
  int cyc = 0;

  logic [95:0]  exp_iw_q[$];
  logic [127:0] exp_dw_q[$];
  logic [63:0]  exp_out_q[$];
  logic [63:0]  stim_q[$];
  logic [63:0]  shadow [logic [63:0]];
  logic [63:0]  mem    [logic [63:0]];

  int en_cycles, en_rises, first_en_cyc, last_wr_cyc, ren_cnt;
  logic         prev_en = 1'b0, prev_ov = 1'b0, prev_hs = 1'b0;
  logic [63:0]  prev_od = '0;
  logic [95:0]  m_ei;
  logic [127:0] m_ed;
  logic [63:0]  m_eo;

  // Data memory responder: read data appears the cycle after ren_ext_2.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (bus.wen_ext_2) mem[bus.addr_ext_2] = bus.wdata_ext_2;
    if (bus.ren_ext_2) bus.rdata_ext_2 <= mem.exists(bus.addr_ext_2) ? mem[bus.addr_ext_2] : 64'd0;
  end

  always @(negedge clk) begin
    if (bus.wen_ext) begin
      chk_cnt++;
      last_wr_cyc = cyc;
      if (exp_iw_q.size() == 0) $display("FAIL imem_write unexpected addr=%h data=%h", bus.addr_ext, bus.wdata_ext);
      else begin
        m_ei = exp_iw_q.pop_front();
        if ({bus.addr_ext, bus.wdata_ext} !== m_ei)
          $display("FAIL imem_write got addr=%h data=%h exp addr=%h data=%h", bus.addr_ext, bus.wdata_ext, m_ei[95:32], m_ei[31:0]);
        else pass_cnt++;
      end
    end
    if (bus.wen_ext_2) begin
      chk_cnt++;
      last_wr_cyc = cyc;
      if (exp_dw_q.size() == 0) $display("FAIL dmem_write unexpected addr=%h data=%h", bus.addr_ext_2, bus.wdata_ext_2);
      else begin
        m_ed = exp_dw_q.pop_front();
        if ({bus.addr_ext_2, bus.wdata_ext_2} !== m_ed)
          $display("FAIL dmem_write got addr=%h data=%h exp addr=%h data=%h", bus.addr_ext_2, bus.wdata_ext_2, m_ed[127:64], m_ed[63:0]);
        else pass_cnt++;
      end
    end
    if (bus.ren_ext_2) ren_cnt++;
    if (bus.wen_ext || bus.wen_ext_2 || bus.ren_ext_2 || bus.ren_ext) begin
      chk_cnt++;
      if ((bus.wen_ext && bus.wen_ext_2) || (bus.ren_ext_2 && bus.wen_ext_2) || bus.ren_ext)
        $display("FAIL port_exclusive wen=%b wen2=%b ren2=%b ren=%b exp no overlap", bus.wen_ext, bus.wen_ext_2, bus.ren_ext_2, bus.ren_ext);
      else pass_cnt++;
    end
    if (bus.cpu_enable) begin
      en_cycles++;
      chk_cnt++;
      if (bus.cpu_arst_n !== 1'b1) $display("FAIL arst_during_run got %b exp 1", bus.cpu_arst_n);
      else pass_cnt++;
      if (!prev_en) begin
        en_rises++;
        first_en_cyc = cyc;
      end
    end
    if (bus.out_valid && prev_ov && !prev_hs) begin
      chk_cnt++;
      if (bus.out_data !== prev_od) $display("FAIL out_stable got %h exp %h", bus.out_data, prev_od);
      else pass_cnt++;
    end
    if (bus.out_valid && bus.out_ready) begin
      chk_cnt++;
      if (exp_out_q.size() == 0) $display("FAIL dump_word unexpected %h", bus.out_data);
      else begin
        m_eo = exp_out_q.pop_front();
        if (bus.out_data !== m_eo) $display("FAIL dump_word got %h exp %h", bus.out_data, m_eo);
        else pass_cnt++;
      end
    end
    prev_en = bus.cpu_enable;
    prev_ov = bus.out_valid;
    prev_hs = bus.out_valid && bus.out_ready;
    prev_od = bus.out_data;
  end

  task automatic run_cmd(input int imem, input int dmem, input int run, input int dump,
                         input bit toggle, input int rdy_wait, input bit poke_run);
    int idx, wait_cnt;
    bit poked, got_done, half;
    logic [63:0] a;
    for (int k = 0; k < imem; k++) exp_iw_q.push_back({64'(k * 4), stim_q[k][31:0]});
    for (int k = 0; k < dmem; k++) begin
      exp_dw_q.push_back({64'(k * 8), stim_q[imem + k]});
      shadow[64'(k * 8)] = stim_q[imem + k];
    end
    for (int j = 0; j < dump; j++) begin
      a = 64'(j * 8);
      exp_out_q.push_back(shadow.exists(a) ? shadow[a] : 64'd0);
    end
    en_cycles = 0; en_rises = 0; ren_cnt = 0; first_en_cyc = -1; last_wr_cyc = -1;
    @(posedge clk); #1;
    bus.imem_words = 16'(imem);
    bus.dmem_words = 16'(dmem);
    bus.run_cycles = 32'(run);
    bus.dump_words = 16'(dump);
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    chk_cnt++;
    if (bus.busy !== 1'b1) $display("FAIL busy_after_start got %b exp 1", bus.busy);
    else pass_cnt++;
    if (imem + dmem > 0) begin
      chk_cnt++;
      if (bus.cpu_arst_n !== 1'b0) $display("FAIL arst_on_start got %b exp 0", bus.cpu_arst_n);
      else pass_cnt++;
    end
    idx = 0; wait_cnt = 0; poked = 0; got_done = 0; half = 0;
    for (int c = 0; c < 4000 && !got_done; c++) begin
      if (bus.done) got_done = 1;
      bus.start = 1'b0;
      if (poke_run && !poked && dbg_state == ST_RUN) begin
        bus.start = 1'b1;
        bus.imem_words = 16'd9; bus.dmem_words = 16'd9;
        bus.run_cycles = 32'd99; bus.dump_words = 16'd9;
        poked = 1;
      end
      if (idx < imem + dmem && (!toggle || !half)) begin
        bus.in_valid = 1'b1;
        bus.in_data  = stim_q[idx];
      end else begin
        bus.in_valid = 1'b0;
        bus.in_data  = {$urandom, $urandom};
      end
      half = ~half;
      if (bus.in_valid && bus.in_ready) idx++;
      if (rdy_wait == 0) bus.out_ready = 1'b1;
      else if (bus.out_valid) begin
        if (wait_cnt < rdy_wait) begin
          bus.out_ready = 1'b0;
          wait_cnt++;
        end else begin
          bus.out_ready = 1'b1;
          wait_cnt = 0;
        end
      end else bus.out_ready = 1'b0;
      if (!got_done) begin
        @(posedge clk); #1;
      end
    end
    bus.in_valid = 1'b0;
    bus.start = 1'b0;
    chk_cnt++;
    if (!got_done) $display("FAIL done_timeout got no done exp done pulse");
    else pass_cnt++;
    @(posedge clk); #1;
    chk_cnt++;
    if ({bus.done, bus.busy, dbg_state} !== {1'b0, 1'b0, ST_IDLE})
      $display("FAIL after_done got done=%b busy=%b state=%0d exp 0 0 0", bus.done, bus.busy, dbg_state);
    else pass_cnt++;
    chk_cnt++;
    if (exp_iw_q.size() + exp_dw_q.size() + exp_out_q.size() != 0)
      $display("FAIL queues_drained got iw=%0d dw=%0d out=%0d exp 0", exp_iw_q.size(), exp_dw_q.size(), exp_out_q.size());
    else pass_cnt++;
    chk_cnt++;
    if (en_cycles != run) $display("FAIL enable_cycles got %0d exp %0d", en_cycles, run);
    else pass_cnt++;
    chk_cnt++;
    if (en_rises != (run > 0 ? 1 : 0)) $display("FAIL enable_contiguous got %0d rises exp %0d", en_rises, run > 0 ? 1 : 0);
    else pass_cnt++;
    if (run > 0 && imem + dmem > 0) begin
      chk_cnt++;
      if (first_en_cyc != last_wr_cyc + 1) $display("FAIL enable_start got cyc %0d exp %0d", first_en_cyc, last_wr_cyc + 1);
      else pass_cnt++;
    end
    chk_cnt++;
    if (ren_cnt != dump) $display("FAIL dump_reads got %0d exp %0d", ren_cnt, dump);
    else pass_cnt++;
    chk_cnt++;
    if (idx != imem + dmem) $display("FAIL words_accepted got %0d exp %0d", idx, imem + dmem);
    else pass_cnt++;
  endtask

  task automatic test_reset();
    bus.start = 1'b0; bus.imem_words = '0; bus.dmem_words = '0;
    bus.run_cycles = '0; bus.dump_words = '0; bus.in_valid = 1'b0;
    bus.in_data = '0; bus.out_ready = 1'b0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk_cnt++;
    if ({bus.busy, bus.done, bus.in_ready, bus.out_valid, bus.wen_ext, bus.wen_ext_2,
         bus.ren_ext_2, bus.cpu_enable, bus.cpu_arst_n, dbg_state} !== 12'd0)
      $display("FAIL reset_ctrl got busy=%b done=%b rdy=%b ov=%b we=%b we2=%b re2=%b en=%b arst_n=%b st=%0d exp all 0",
               bus.busy, bus.done, bus.in_ready, bus.out_valid, bus.wen_ext, bus.wen_ext_2,
               bus.ren_ext_2, bus.cpu_enable, bus.cpu_arst_n, dbg_state);
    else pass_cnt++;
    chk_cnt++;
    if ({bus.addr_ext, bus.addr_ext_2, bus.out_data} !== 192'd0)
      $display("FAIL reset_data got addr=%h addr2=%h out=%h exp 0", bus.addr_ext, bus.addr_ext_2, bus.out_data);
    else pass_cnt++;
    rst = 1'b0;
  endtask

  task automatic test_reset_mid();
    int idx;
    bit seen;
    stim_q = '{64'h1111_2222_0000_0013, 64'hDEAD_0000_0000_00A1, 64'hBEEF_0000_0000_00A2, 64'h0000_0000_0000_00A3};
    exp_iw_q.push_back({64'd0, stim_q[0][31:0]});
    exp_dw_q.push_back({64'd0, stim_q[1]});
    shadow[64'd0] = stim_q[1];
    @(posedge clk); #1;
    bus.imem_words = 16'd1; bus.dmem_words = 16'd3;
    bus.run_cycles = 32'd4; bus.dump_words = 16'd1;
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    idx = 0; seen = 0;
    for (int c = 0; c < 50 && !seen; c++) begin
      if (bus.wen_ext_2 && dbg_state == ST_LOAD_D) seen = 1;
      else begin
        bus.in_valid = 1'b1;
        bus.in_data  = stim_q[idx];
        if (bus.in_ready) idx++;
        @(posedge clk); #1;
      end
    end
    chk_cnt++;
    if (!seen) $display("FAIL mid_reset_setup got no dmem write exp one");
    else pass_cnt++;
    rst = 1'b1;
    @(posedge clk); #1;
    chk_cnt++;
    if ({bus.wen_ext_2, bus.busy, bus.cpu_arst_n, bus.in_ready, dbg_state} !== {4'b0000, ST_IDLE})
      $display("FAIL mid_reset got we2=%b busy=%b arst_n=%b rdy=%b st=%0d exp 0 0 0 0 0",
               bus.wen_ext_2, bus.busy, bus.cpu_arst_n, bus.in_ready, dbg_state);
    else pass_cnt++;
    bus.in_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    chk_cnt++;
    if (exp_iw_q.size() + exp_dw_q.size() != 0 || bus.busy !== 1'b0)
      $display("FAIL mid_reset_drain got iw=%0d dw=%0d busy=%b exp 0 0 0", exp_iw_q.size(), exp_dw_q.size(), bus.busy);
    else pass_cnt++;
  endtask

  task automatic test_basic();
    stim_q = '{64'h13, 64'h93, 64'h113, 64'hA, 64'hB};
    run_cmd(3, 2, 5, 2, 1'b0, 0, 1'b0);
  endtask

  task automatic test_stall();
    stim_q = '{64'h13, 64'h93, 64'h113, 64'hA, 64'hB};
    run_cmd(3, 2, 5, 2, 1'b1, 3, 1'b0);
  endtask

  task automatic test_zero_counts();
    stim_q.delete();
    run_cmd(0, 0, 0, 1, 1'b0, 0, 1'b0);
  endtask

  task automatic test_start_in_run();
    stim_q = '{64'h0000_0000_0000_0777, 64'h0123_4567_89AB_CDEF};
    run_cmd(1, 1, 6, 1, 1'b0, 1, 1'b1);
  endtask

  task automatic test_back_to_back();
    chk_cnt++;
    if (bus.cpu_arst_n !== 1'b1) $display("FAIL arst_held_idle got %b exp 1", bus.cpu_arst_n);
    else pass_cnt++;
    stim_q.delete();
    for (int k = 0; k < 5; k++) stim_q.push_back({$urandom, $urandom});
    run_cmd(2, 3, $urandom_range(1, 7), 3, 1'b0, $urandom_range(0, 2), 1'b0);
  endtask

  initial begin
    test_reset();
    test_reset_mid();
    test_basic();
    test_stall();
    test_zero_counts();
    test_start_in_run();
    test_back_to_back();
    repeat (2) @(posedge clk);
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
